// File: rtl/password_receiver.sv
// password_receiver: assembles byte-serial password frames, compares each against a secret, and counts failures.
// Define PWRX_LOCKOUT_EN to build the timed lockout after MAX_FAILS consecutive failures.
module password_receiver #(
    parameter int PW_BYTES    = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int GAP_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic [8*PW_BYTES-1:0] secret,
    output logic                  auth_ok,
    output logic                  auth_fail,
    output logic                  frame_drop,
    output logic                  locked,
    output logic                  busy,
    output logic [3:0]            fail_count
);
    localparam int CW = $clog2(PW_BYTES + 1);

    if (PW_BYTES < 2 || PW_BYTES > 16 || MAX_FAILS < 1 || MAX_FAILS > 15 ||
        LOCK_CYCLES < 1 || LOCK_CYCLES > 65535 || GAP_TIMEOUT < 1 || GAP_TIMEOUT > 255) begin : g_bad_params
        $error("password_receiver: parameter out of legal range");
    end

`ifdef PWRX_LOCKOUT_EN
    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, LOCKED} state_t;
    logic [15:0] lock_q, lock_d;
`else
    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;
`endif

    state_t                state_q, state_d;
    logic [8*PW_BYTES-1:0] frame_q, frame_d;
    logic [CW-1:0]         count_q, count_d;
    logic [7:0]            gap_q, gap_d;
    logic [3:0]            fails_q, fails_d;
    logic                  auth_ok_q, auth_ok_d;
    logic                  auth_fail_q, auth_fail_d;
    logic                  frame_drop_q, frame_drop_d;

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        count_d      = count_q;
        gap_d        = gap_q;
        fails_d      = fails_q;
        auth_ok_d    = 1'b0;
        auth_fail_d  = 1'b0;
        frame_drop_d = 1'b0;
`ifdef PWRX_LOCKOUT_EN
        lock_d       = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    frame_d[7:0] = rx_data;
                    count_d      = CW'(1);
                    gap_d        = 8'd0;
                    state_d      = COLLECT;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    frame_d[8*count_q +: 8] = rx_data;
                    count_d = count_q + CW'(1);
                    gap_d   = 8'd0;
                    state_d = (count_q == CW'(PW_BYTES - 1)) ? CHECK : COLLECT;
                end else if (gap_q == 8'(GAP_TIMEOUT - 1)) begin
                    frame_d      = '0;
                    count_d      = '0;
                    gap_d        = 8'd0;
                    frame_drop_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            CHECK: begin
                // rx_valid is deliberately ignored here; the secret is only sampled in this cycle
                frame_d = '0;
                count_d = '0;
                state_d = IDLE;
                if (frame_q == secret) begin
                    auth_ok_d = 1'b1;
                    fails_d   = 4'd0;
                end else begin
                    auth_fail_d = 1'b1;
`ifdef PWRX_LOCKOUT_EN
                    fails_d = fails_q + 4'd1;
                    if (fails_d == 4'(MAX_FAILS)) begin
                        lock_d  = 16'(LOCK_CYCLES);
                        state_d = LOCKED;
                    end
`else
                    fails_d = (fails_q == 4'hf) ? fails_q : fails_q + 4'd1;
`endif
                end
            end
`ifdef PWRX_LOCKOUT_EN
            LOCKED: begin
                lock_d  = lock_q - 16'd1;
                state_d = (lock_q == 16'd1) ? IDLE : LOCKED;
                fails_d = (lock_q == 16'd1) ? 4'd0 : fails_q;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            count_q      <= '0;
            gap_q        <= 8'd0;
            fails_q      <= 4'd0;
            auth_ok_q    <= 1'b0;
            auth_fail_q  <= 1'b0;
            frame_drop_q <= 1'b0;
`ifdef PWRX_LOCKOUT_EN
            lock_q       <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            count_q      <= count_d;
            gap_q        <= gap_d;
            fails_q      <= fails_d;
            auth_ok_q    <= auth_ok_d;
            auth_fail_q  <= auth_fail_d;
            frame_drop_q <= frame_drop_d;
`ifdef PWRX_LOCKOUT_EN
            lock_q       <= lock_d;
`endif
        end
    end

    assign auth_ok    = auth_ok_q;
    assign auth_fail  = auth_fail_q;
    assign frame_drop = frame_drop_q;
    assign fail_count = fails_q;
    assign busy       = (state_q == COLLECT) || (state_q == CHECK);
`ifdef PWRX_LOCKOUT_EN
    assign locked     = (state_q == LOCKED);
`else
    assign locked     = 1'b0;
`endif
endmodule

// File: tb/tb_password_receiver.sv
// tb_password_receiver: table-driven frames plus hand sequences, checked through a pulse scoreboard.
module tb_password_receiver;
    localparam int GAP_TIMEOUT = 8;
    localparam logic [31:0] SECRET = 32'h44332211;
    localparam logic [31:0] WRONG  = 32'h45332211;
    localparam logic [2:0] P_OK = 3'b100, P_FAIL = 3'b010, P_DROP = 3'b001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [31:0] secret = SECRET;
    logic        auth_ok, auth_fail, frame_drop, locked, busy;
    logic [3:0]  fail_count;

    int vectors = 0, miscompares = 0, cyc = 0, locked_cycles = 0;

    typedef struct { logic [2:0] pulse; logic [3:0] fc; logic lk; int due; } exp_t;
    typedef struct { logic [31:0] data; int n; logic [2:0] pulse; logic [3:0] fc; } vec_t;
    exp_t sbq[$];
    vec_t vt[6];

    password_receiver #(.PW_BYTES(4), .MAX_FAILS(3), .LOCK_CYCLES(16), .GAP_TIMEOUT(GAP_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .secret(secret),
        .auth_ok(auth_ok), .auth_fail(auth_fail), .frame_drop(frame_drop),
        .locked(locked), .busy(busy), .fail_count(fail_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_pulse(input logic [2:0] p, input logic [3:0] fc, input logic lk);
        exp_t e;
        e.pulse = p; e.fc = fc; e.lk = lk;
        e.due = cyc + ((p == P_DROP) ? GAP_TIMEOUT : 1);
        sbq.push_back(e);
    endtask

    task automatic send(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = d[8*i +: 8];
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'd0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (locked) locked_cycles++;
            if (auth_ok || auth_fail || frame_drop) begin
                if (sbq.size() == 0) check("unexpected_pulse", {auth_ok, auth_fail, frame_drop}, 3'b000);
                else begin
                    e = sbq.pop_front();
                    check("pulse", {auth_ok, auth_fail, frame_drop}, e.pulse);
                    check("latency_cycle", cyc, e.due);
                    check("fail_count", fail_count, e.fc);
                    check("locked_at_pulse", locked, e.lk);
                end
            end else if (sbq.size() > 0 && cyc >= sbq[0].due) begin
                e = sbq.pop_front();
                check("missing_pulse", 3'b000, e.pulse);
            end
        end
    end

    initial begin
        int exp_fc;
        vt[0] = '{SECRET,        4, P_OK,   4'd0};
        vt[1] = '{WRONG,         4, P_FAIL, 4'd1};
        vt[2] = '{SECRET,        4, P_OK,   4'd0};
        vt[3] = '{32'h00000000,  4, P_FAIL, 4'd1};
        vt[4] = '{32'h44332212,  4, P_FAIL, 4'd2};
        vt[5] = '{32'h00002211,  2, P_DROP, 4'd2};

        @(posedge clk); #1;
        check("reset_outputs", {auth_ok, auth_fail, frame_drop, locked, busy, fail_count}, 9'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            send(vt[i].data, vt[i].n);
            if (vt[i].n == 2) check("busy_partial", busy, 1'b1);
            expect_pulse(vt[i].pulse, vt[i].fc, 1'b0);
            idle(12);
        end

`ifdef PWRX_LOCKOUT_EN
        locked_cycles = 0;
        send(WRONG, 4);
        expect_pulse(P_FAIL, 4'd3, 1'b1);
        idle(3);
        send(SECRET, 4);
        for (int i = 0; i < 40 && locked; i++) @(negedge clk);
        check("lock_released", locked, 1'b0);
        check("lock_length", locked_cycles, 16);
        check("fc_after_lock", fail_count, 4'd0);
        send(SECRET, 4);
        expect_pulse(P_OK, 4'd0, 1'b0);
        idle(5);
`else
        exp_fc = 2;
        for (int i = 0; i < 16; i++) begin
            send(WRONG, 4);
            exp_fc = (exp_fc == 15) ? 15 : exp_fc + 1;
            expect_pulse(P_FAIL, 4'(exp_fc), 1'b0);
            idle(3);
        end
        check("fc_saturated", fail_count, 4'd15);
        check("never_locked", locked, 1'b0);
        send(SECRET, 4);
        expect_pulse(P_OK, 4'd0, 1'b0);
        idle(5);
`endif

        send(32'h00002211, 2);
        idle(GAP_TIMEOUT - 1);
        send(32'h00004433, 2);
        expect_pulse(P_OK, 4'd0, 1'b0);
        idle(12);

        send(SECRET, 4);
        expect_pulse(P_OK, 4'd0, 1'b0);
        send(32'h00000011, 1);
        idle(3);
        check("idle_after_check_byte", busy, 1'b0);
        send(SECRET, 4);
        expect_pulse(P_OK, 4'd0, 1'b0);
        idle(5);

        send(WRONG, 4);
        expect_pulse(P_FAIL, 4'd1, 1'b0);
        idle(3);
        send(32'h00002211, 2);
        check("busy_before_reset", busy, 1'b1);
        #2 reset = 1'b1;
        #1 check("reset_midframe", {auth_ok, auth_fail, frame_drop, locked, busy, fail_count}, 9'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
        send(SECRET, 4);
        expect_pulse(P_OK, 4'd0, 1'b0);
        idle(20);

        check("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
